// File: rtl/sha256_arb_pkg.sv
// rtl/sha256_arb_pkg.sv - shared types, widths and helpers for the SHA-256 core arbiter
package sha256_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    localparam int SHA256_BLOCK_W  = 512;
    localparam int SHA256_DIGEST_W = 256;

    // Bits needed to hold the values 0..value-1 (never less than one).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_arb_rr_pick.sv
// rtl/sha256_arb_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
//
// Ports:
//   req   [N-1:0]      candidate request vector
//   ptr   [IDX_W-1:0]  highest-priority index (must be < N)
//   valid              at least one request set
//   idx   [IDX_W-1:0]  winning index (0 when valid is low)
module sha256_arb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Scan from the farthest position back towards ptr so the nearest hit is
    // the last assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sha256_core_arb.sv
// rtl/sha256_core_arb.sv - message-granular round-robin arbiter sharing one sha256_core
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   zeroize             synchronous clear, forwarded combinationally to the core
//   req_valid/init/last/mode [NUM_REQ]   per-requester block request and flags
//   req_block [NUM_REQ*512]              requester i occupies bits [i*512 +: 512], word 0 in MSBs
//   req_ready [NUM_REQ]                  combinational accept pulse
//   rsp_valid [NUM_REQ], rsp_digest      one-hot done pulse and digest of last finished message
//   protocol_err                         one-cycle pulse: hold timeout or non-init block while unlocked
//   core_*                               command/data interface to the shared core
module sha256_core_arb
    import sha256_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                zeroize,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_init,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ-1:0]                  req_mode,
    input  logic [NUM_REQ*SHA256_BLOCK_W-1:0]   req_block,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [SHA256_DIGEST_W-1:0]          rsp_digest,
    output logic                                protocol_err,
    output logic                                core_init_cmd,
    output logic                                core_next_cmd,
    output logic                                core_mode,
    output logic                                core_zeroize,
    output logic [SHA256_BLOCK_W-1:0]           core_block,
    input  logic                                core_ready,
    input  logic                                core_digest_valid,
    input  logic [SHA256_DIGEST_W-1:0]          core_digest
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = clog2(HOLD_TIMEOUT);

    state_t                      state;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            owner;
    logic                        locked;
    logic [TMR_W-1:0]            timer;
    logic [SHA256_BLOCK_W-1:0]   buffer;
    logic                        mode_q;
    logic                        init_q;
    logic                        last_q;

    logic [NUM_REQ-1:0]          init_req;
    logic                        init_hit;
    logic                        any_hit;
    logic [IDX_W-1:0]            init_idx;
    logic [IDX_W-1:0]            any_idx;
    logic                        accept;
    logic                        discard;
    logic [IDX_W-1:0]            sel;
    logic                        timed_out;
    logic [IDX_W-1:0]            owner_next;

    // Completion is tracked through core_ready alone; the core's digest strobe
    // coincides with it and carries no extra information here.
    logic                        unused_digest_valid;
    assign unused_digest_valid = core_digest_valid;

    assign init_req = req_valid & req_init;

    sha256_arb_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_init (
        .req   (init_req),
        .ptr   (rr_ptr),
        .valid (init_hit),
        .idx   (init_idx)
    );

    // Only consulted when nobody is starting a message: its winner is then
    // necessarily a stray continuation block, which gets discarded.
    sha256_arb_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_any (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .valid (any_hit),
        .idx   (any_idx)
    );

    always_comb begin
        accept    = 1'b0;
        discard   = 1'b0;
        sel       = init_idx;
        req_ready = '0;
        if (reset_n && !zeroize && core_ready) begin
            if (state == IDLE) begin
                if (init_hit) begin
                    accept = 1'b1;
                    sel    = init_idx;
                end else if (any_hit) begin
                    discard = 1'b1;
                    sel     = any_idx;
                end
            end else if (state == HOLD && locked && req_valid[owner]) begin
                accept = 1'b1;
                sel    = owner;
            end
        end
        if (accept || discard) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign timed_out  = (state == HOLD) && !accept && (timer == TMR_W'(HOLD_TIMEOUT - 1));
    assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    assign core_init_cmd = (state == ISSUE) && !zeroize && init_q;
    assign core_next_cmd = (state == ISSUE) && !zeroize && !init_q;
    assign core_mode     = mode_q;
    assign core_zeroize  = zeroize;
    assign core_block    = buffer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            locked       <= 1'b0;
            timer        <= '0;
            buffer       <= '0;
            mode_q       <= 1'b0;
            init_q       <= 1'b0;
            last_q       <= 1'b0;
            rsp_valid    <= '0;
            rsp_digest   <= '0;
            protocol_err <= 1'b0;
        end else begin
            rsp_valid    <= '0;
            protocol_err <= 1'b0;
            if (zeroize) begin
                state      <= IDLE;
                locked     <= 1'b0;
                timer      <= '0;
                buffer     <= '0;
                rsp_digest <= '0;
            end else if (accept) begin
                buffer <= req_block[int'(sel)*SHA256_BLOCK_W +: SHA256_BLOCK_W];
                mode_q <= req_mode[sel];
                init_q <= req_init[sel];
                last_q <= req_last[sel];
                owner  <= sel;
                locked <= 1'b1;
                timer  <= '0;
                state  <= ISSUE;
            end else begin
                case (state)
                    IDLE: begin
                        if (discard) begin
                            protocol_err <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (!core_ready) begin
                            state <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (core_ready) begin
                            if (last_q) begin
                                rsp_digest       <= core_digest;
                                rsp_valid[owner] <= 1'b1;
                                locked           <= 1'b0;
                                rr_ptr           <= owner_next;
                                state            <= IDLE;
                            end else begin
                                timer <= '0;
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (timed_out) begin
                            protocol_err <= 1'b1;
                            locked       <= 1'b0;
                            timer        <= '0;
                            rr_ptr       <= owner_next;
                            state        <= IDLE;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_core_arb.sv
// tb/tb_sha256_core_arb.sv - directed self-checking bench for sha256_core_arb with a behavioural SHA-256 core
module tb_sha256_core_arb;

    localparam int NUM_REQ      = 2;
    localparam int HOLD_TIMEOUT = 16;

    localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] TWO_BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2 = {{15{32'h00000000}}, 32'h000001c0};
    localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] SHA_IV   = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [2047:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  zeroize = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_init = '0;
    logic [NUM_REQ-1:0]    req_last = '0;
    logic [NUM_REQ-1:0]    req_mode = '0;
    logic [NUM_REQ*512-1:0] req_block = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [255:0]          rsp_digest;
    logic                  protocol_err;
    logic                  core_init_cmd;
    logic                  core_next_cmd;
    logic                  core_mode;
    logic                  core_zeroize;
    logic [511:0]          core_block;
    logic                  core_ready;
    logic                  core_digest_valid;
    logic [255:0]          core_digest;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sha256_core_arb #(.NUM_REQ(NUM_REQ), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .zeroize           (zeroize),
        .req_valid         (req_valid),
        .req_init          (req_init),
        .req_last          (req_last),
        .req_mode          (req_mode),
        .req_block         (req_block),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_digest        (rsp_digest),
        .protocol_err      (protocol_err),
        .core_init_cmd     (core_init_cmd),
        .core_next_cmd     (core_next_cmd),
        .core_mode         (core_mode),
        .core_zeroize      (core_zeroize),
        .core_block        (core_block),
        .core_ready        (core_ready),
        .core_digest_valid (core_digest_valid),
        .core_digest       (core_digest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural SHA-256 core ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[2047-32*i -: 32] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    logic [255:0] h_state;
    int           busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready        <= 1'b1;
            core_digest_valid <= 1'b0;
            core_digest       <= '0;
            h_state           <= '0;
            busy              <= 0;
        end else begin
            core_digest_valid <= 1'b0;
            if (core_zeroize) begin
                core_ready  <= 1'b1;
                core_digest <= '0;
                h_state     <= '0;
                busy        <= 0;
            end else if (busy != 0) begin
                busy <= busy - 1;
                if (busy == 1) begin
                    core_ready        <= 1'b1;
                    core_digest_valid <= 1'b1;
                    core_digest       <= h_state;
                end
            end else if (core_ready && (core_init_cmd || core_next_cmd)) begin
                h_state    <= compress(core_init_cmd ? SHA_IV : h_state, core_block);
                core_ready <= 1'b0;
                busy       <= 4;
            end
        end
    end

    // ---------------- traffic driver and event log ----------------
    logic [511:0] q_blk [2][2];
    logic         q_init [2][2];
    logic         q_last [2][2];
    int           q_len [2];
    int           q_pos [2];

    int           ready_cyc [2];
    int           ready_last [2];
    int           ready_cnt [2];
    int           rsp_cyc [2];
    int           rsp_cnt [2];
    logic [255:0] rsp_dig [2];
    int           err_cnt, err_cyc, init_cnt, next_cnt, init_first, done_first;
    logic         init_mode;
    logic [511:0] init_blk;

    task automatic clear_log();
        for (int i = 0; i < 2; i++) begin
            q_len[i] = 0; q_pos[i] = 0;
            ready_cyc[i] = -1; ready_last[i] = -1; ready_cnt[i] = 0;
            rsp_cyc[i] = -1; rsp_cnt[i] = 0; rsp_dig[i] = '0;
        end
        err_cnt = 0; err_cyc = -1; init_cnt = 0; next_cnt = 0;
        init_first = -1; done_first = -1; init_mode = 1'b0; init_blk = '0;
    endtask

    task automatic queue_block(input int r, input logic [511:0] b, input logic ini, input logic lst);
        q_blk[r][q_len[r]]  = b;
        q_init[r][q_len[r]] = ini;
        q_last[r][q_len[r]] = lst;
        q_len[r] = q_len[r] + 1;
    endtask

    // Each requester presents its queued blocks in order, advancing on req_ready.
    task automatic run_traffic(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (q_pos[i] < q_len[i]) begin
                    req_valid[i] = 1'b1;
                    req_init[i]  = q_init[i][q_pos[i]];
                    req_last[i]  = q_last[i][q_pos[i]];
                    req_mode[i]  = 1'b1;
                    req_block[i*512 +: 512] = q_blk[i][q_pos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            #2;
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    if (ready_cyc[i] < 0) ready_cyc[i] = cyc;
                    ready_last[i] = cyc;
                    ready_cnt[i]  = ready_cnt[i] + 1;
                    q_pos[i]      = q_pos[i] + 1;
                end
                if (rsp_valid[i]) begin
                    if (rsp_cyc[i] < 0) rsp_cyc[i] = cyc;
                    rsp_cnt[i] = rsp_cnt[i] + 1;
                    rsp_dig[i] = rsp_digest;
                end
            end
            if (protocol_err) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
            if (core_init_cmd) begin
                if (init_first < 0) begin init_first = cyc; init_mode = core_mode; init_blk = core_block; end
                init_cnt = init_cnt + 1;
            end
            if (core_next_cmd) next_cnt = next_cnt + 1;
            if (core_digest_valid && done_first < 0) done_first = cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; zeroize = 1'b0; req_valid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        req_valid = 2'b11; req_init = 2'b11; req_last = 2'b11; req_mode = 2'b11;
        #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if ({rsp_valid, protocol_err} !== 3'b000) begin errors++; $display("FAIL reset_rsp_err: got %b expected 000", {rsp_valid, protocol_err}); end
        checks++; if ({core_init_cmd, core_next_cmd, core_mode, core_zeroize} !== 4'b0000) begin errors++; $display("FAIL reset_core_ctl: got %b expected 0000", {core_init_cmd, core_next_cmd, core_mode, core_zeroize}); end
        checks++; if (core_block !== '0) begin errors++; $display("FAIL reset_core_block: got %h expected 0", core_block); end
        checks++; if (rsp_digest !== '0) begin errors++; $display("FAIL reset_rsp_digest: got %h expected 0", rsp_digest); end
        @(negedge clk);
        req_valid = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single_abc();
        clear_log();
        queue_block(0, ABC_BLK, 1'b1, 1'b1);
        run_traffic(20);
        checks++; if (ready_cnt[0] !== 1) begin errors++; $display("FAIL abc_ready_count: got %0d expected 1", ready_cnt[0]); end
        checks++; if (init_first !== ready_cyc[0] + 1) begin errors++; $display("FAIL abc_init_latency: init at %0d expected %0d", init_first, ready_cyc[0] + 1); end
        checks++; if ({init_cnt, next_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL abc_cmds: init %0d next %0d expected 1 0", init_cnt, next_cnt); end
        checks++; if ({init_mode, init_blk} !== {1'b1, ABC_BLK}) begin errors++; $display("FAIL abc_core_inputs: mode %b block %h expected 1 %h", init_mode, init_blk, ABC_BLK); end
        checks++; if (rsp_cnt[0] !== 1 || rsp_cnt[1] !== 0) begin errors++; $display("FAIL abc_rsp_count: got %0d/%0d expected 1/0", rsp_cnt[0], rsp_cnt[1]); end
        checks++; if (rsp_cyc[0] !== done_first + 1) begin errors++; $display("FAIL abc_rsp_latency: rsp at %0d expected %0d", rsp_cyc[0], done_first + 1); end
        checks++; if (rsp_dig[0] !== ABC_DIG) begin errors++; $display("FAIL abc_digest: got %h expected %h", rsp_dig[0], ABC_DIG); end
    endtask

    task automatic test_zeroize();
        @(negedge clk);
        zeroize = 1'b1;
        req_valid = 2'b01; req_init = 2'b01; req_last = 2'b01; req_mode = 2'b01;
        req_block[511:0] = ABC_BLK;
        #2;
        checks++; if ({req_ready, core_zeroize} !== 3'b001) begin errors++; $display("FAIL zero_blocks_ready: ready/zeroize %b expected 001", {req_ready, core_zeroize}); end
        @(negedge clk);
        zeroize = 1'b0;
        #2;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL zero_accept: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #2;
        checks++; if (core_init_cmd !== 1'b1) begin errors++; $display("FAIL zero_issue: init_cmd %b expected 1", core_init_cmd); end
        @(negedge clk);
        zeroize = 1'b1;
        #2;
        checks++; if (core_zeroize !== 1'b1) begin errors++; $display("FAIL zero_forward: got %b expected 1", core_zeroize); end
        @(negedge clk);
        zeroize = 1'b0;
        req_valid = 2'b10; req_init = 2'b10; req_last = 2'b10; req_mode = 2'b10;
        req_block[1023:512] = ABC_BLK;
        #2;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_idle_next: ready %b expected 10", req_ready); end
        checks++; if ({rsp_digest, core_block} !== '0) begin errors++; $display("FAIL zero_cleared: digest %h block %h expected 0", rsp_digest, core_block); end
        clear_log();
        run_traffic(25);
        checks++; if (rsp_cnt[0] !== 0 || rsp_cnt[1] !== 1) begin errors++; $display("FAIL zero_rsp: got %0d/%0d expected 0/1", rsp_cnt[0], rsp_cnt[1]); end
        checks++; if (rsp_dig[1] !== ABC_DIG) begin errors++; $display("FAIL zero_restart_digest: got %h expected %h", rsp_dig[1], ABC_DIG); end
    endtask

    task automatic test_two_req();
        do_reset();
        clear_log();
        queue_block(0, ABC_BLK, 1'b1, 1'b1);
        queue_block(1, ABC_BLK, 1'b1, 1'b1);
        run_traffic(40);
        checks++; if (!(ready_cyc[0] >= 0 && ready_cyc[0] < ready_cyc[1])) begin errors++; $display("FAIL both_grant_order: ready0 %0d ready1 %0d, req0 first required", ready_cyc[0], ready_cyc[1]); end
        checks++; if (!(rsp_cyc[0] >= 0 && rsp_cyc[0] < rsp_cyc[1])) begin errors++; $display("FAIL both_rsp_order: rsp0 %0d rsp1 %0d, rsp0 first required", rsp_cyc[0], rsp_cyc[1]); end
        checks++; if (rsp_dig[1] !== ABC_DIG) begin errors++; $display("FAIL both_digest1: got %h expected %h", rsp_dig[1], ABC_DIG); end
    endtask

    task automatic test_two_block();
        do_reset();
        clear_log();
        queue_block(0, TWO_BLK1, 1'b1, 1'b0);
        queue_block(0, TWO_BLK2, 1'b0, 1'b1);
        queue_block(1, ABC_BLK, 1'b1, 1'b1);
        run_traffic(60);
        checks++; if (rsp_cnt[0] !== 1 || rsp_dig[0] !== TWO_DIG) begin errors++; $display("FAIL two_digest: count %0d got %h expected %h", rsp_cnt[0], rsp_dig[0], TWO_DIG); end
        checks++; if (!(rsp_cyc[0] >= 0 && ready_cyc[1] >= rsp_cyc[0])) begin errors++; $display("FAIL two_lock: ready1 %0d rsp0 %0d, ready1 not before rsp0 required", ready_cyc[1], rsp_cyc[0]); end
        checks++; if (ready_last[0] !== done_first + 1) begin errors++; $display("FAIL two_block2_latency: block2 ready %0d expected %0d", ready_last[0], done_first + 1); end
        checks++; if (next_cnt !== 1) begin errors++; $display("FAIL two_next_cmd: got %0d expected 1", next_cnt); end
        checks++; if (rsp_cnt[1] !== 1 || rsp_dig[1] !== ABC_DIG) begin errors++; $display("FAIL two_then_req1: count %0d got %h expected %h", rsp_cnt[1], rsp_dig[1], ABC_DIG); end
    endtask

    task automatic test_timeout();
        do_reset();
        clear_log();
        queue_block(0, TWO_BLK1, 1'b1, 1'b0);
        queue_block(1, ABC_BLK, 1'b1, 1'b1);
        run_traffic(60);
        checks++; if (err_cnt !== 1 || err_cyc !== done_first + 1 + HOLD_TIMEOUT) begin errors++; $display("FAIL tmo_err: count %0d at %0d expected 1 at %0d", err_cnt, err_cyc, done_first + 1 + HOLD_TIMEOUT); end
        checks++; if (ready_cyc[1] !== err_cyc) begin errors++; $display("FAIL tmo_req1_grant: at %0d expected %0d", ready_cyc[1], err_cyc); end
        checks++; if (rsp_cnt[0] !== 0 || rsp_cnt[1] !== 1) begin errors++; $display("FAIL tmo_rsp: got %0d/%0d expected 0/1", rsp_cnt[0], rsp_cnt[1]); end
    endtask

    task automatic test_discard();
        do_reset();
        clear_log();
        queue_block(1, ABC_BLK, 1'b0, 1'b1);
        run_traffic(15);
        checks++; if (ready_cnt[1] !== 1) begin errors++; $display("FAIL disc_ack: got %0d expected 1", ready_cnt[1]); end
        checks++; if (err_cnt !== 1 || err_cyc !== ready_cyc[1] + 1) begin errors++; $display("FAIL disc_err: count %0d at %0d expected 1 at %0d", err_cnt, err_cyc, ready_cyc[1] + 1); end
        checks++; if (init_cnt + next_cnt + rsp_cnt[0] + rsp_cnt[1] !== 0) begin errors++; $display("FAIL disc_no_cmd: cmds %0d rsps %0d expected 0 0", init_cnt + next_cnt, rsp_cnt[0] + rsp_cnt[1]); end
        clear_log();
        queue_block(0, ABC_BLK, 1'b0, 1'b1);
        run_traffic(5);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL disc0_err: got %0d expected 1", err_cnt); end
        clear_log();
        queue_block(0, ABC_BLK, 1'b1, 1'b1);
        queue_block(1, ABC_BLK, 1'b1, 1'b1);
        run_traffic(40);
        checks++; if (!(ready_cyc[0] >= 0 && ready_cyc[0] < ready_cyc[1])) begin errors++; $display("FAIL disc_ptr_kept: ready0 %0d ready1 %0d, req0 first required", ready_cyc[0], ready_cyc[1]); end
    endtask

    initial begin
        test_reset();
        test_single_abc();
        test_zeroize();
        test_two_req();
        test_two_block();
        test_timeout();
        test_discard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
